// File: rtl/lilypad_lanes.sv
// Four independent lily-pad lanes for a frogger-style playfield: each lane
// steps its pad left or right by STEP pixels once every Speed frames, wrapping across X_MAX.
module lilypad_lanes #(
  parameter int STEP  = 40,
  parameter int X_MAX = 640,
  parameter int PAD_W = 80
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        Restart,
  input  logic        Enable,
  input  logic [1:0]  Level,
  output logic [10:0] LPad_X [0:3],
  output logic [10:0] LPad_Width,
  output logic [5:0]  LPad_Speed [0:3],
  output logic [5:0]  LPad_Remainder_Count [3:0],
  output logic        LPad_Direction [0:3],
  output logic [3:0]  LPad_Step
);

  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] X_MAX_W = 11'(X_MAX);

  function automatic logic [5:0] speed_lut(input logic [1:0] lvl, input int lane);
    logic [5:0] row [0:3];
    case (lvl)
      2'd0:    row = '{6'd30, 6'd20, 6'd40, 6'd25};
      2'd1:    row = '{6'd20, 6'd14, 6'd28, 6'd18};
      2'd2:    row = '{6'd12, 6'd9,  6'd16, 6'd10};
      default: row = '{6'd6,  6'd5,  6'd8,  6'd6};
    endcase
    return row[lane];
  endfunction

  function automatic logic [10:0] start_x(input int lane);
    logic [10:0] tbl [0:3];
    tbl = '{11'd80, 11'd320, 11'd200, 11'd440};
    return tbl[lane];
  endfunction

  function automatic logic [10:0] next_x(input logic [10:0] x, input logic right);
    logic [10:0] sum;
    if (right) begin
      sum = x + STEP_W;
      return (sum >= X_MAX_W) ? sum - X_MAX_W : sum;
    end
    return (x < STEP_W) ? x + X_MAX_W - STEP_W : x - STEP_W;
  endfunction

  assign LPad_Width = 11'(PAD_W);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    localparam logic DIR = (l % 2) == 1;

    logic [10:0] x_q,   x_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [5:0]  spd_q, spd_d;
    logic        step;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
      step  = Enable && !Restart && (cnt_q == spd_q - 6'd1);
      x_d   = x_q;
      cnt_d = cnt_q;
      spd_d = spd_q;
      if (Restart) begin
        x_d   = start_x(l);
        cnt_d = '0;
        spd_d = speed_lut(Level, l);
      end else if (Enable) begin
        if (step) begin
          cnt_d = '0;
          x_d   = next_x(x_q, DIR);
          // Speed reloads only at a period boundary so a Level change never stretches the current period.
          spd_d = speed_lut(Level, l);
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
    end

    // NOTE: state registers use non-blocking assignments so all lanes sample the same pre-edge values.
    always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
        x_q   <= start_x(l);
        cnt_q <= '0;
        spd_q <= speed_lut(2'd0, l);
      end else begin
        x_q   <= x_d;
        cnt_q <= cnt_d;
        spd_q <= spd_d;
      end
    end

    assign LPad_X[l]               = x_q;
    assign LPad_Speed[l]           = spd_q;
    assign LPad_Remainder_Count[l] = cnt_q;
    assign LPad_Direction[l]       = DIR;
    assign LPad_Step[l]            = step;
  end

endmodule

// File: tb/tb_lilypad_lanes.sv
// Randomized and directed bench for lilypad_lanes, checked against an
// integer model of the lane rules (modular X arithmetic, frame counters).
module tb_lilypad_lanes;
  localparam int STEP  = 40;
  localparam int X_MAX = 640;
  localparam int PAD_W = 80;
  localparam int START_X [4] = '{80, 320, 200, 440};
  localparam int SPD [4][4] = '{'{30, 20, 40, 25}, '{20, 14, 28, 18},
                                '{12, 9, 16, 10},  '{6, 5, 8, 6}};
  localparam int DIRS [4] = '{0, 1, 0, 1};

  logic        frame_clk = 1'b0;
  logic        Reset     = 1'b0;
  logic        Restart   = 1'b0;
  logic        Enable    = 1'b0;
  logic [1:0]  Level     = 2'd0;
  logic [10:0] LPad_X [0:3];
  logic [10:0] LPad_Width;
  logic [5:0]  LPad_Speed [0:3];
  logic [5:0]  LPad_Remainder_Count [3:0];
  logic        LPad_Direction [0:3];
  logic [3:0]  LPad_Step;

  lilypad_lanes #(.STEP(STEP), .X_MAX(X_MAX), .PAD_W(PAD_W)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .Restart(Restart), .Enable(Enable),
    .Level(Level), .LPad_X(LPad_X), .LPad_Width(LPad_Width), .LPad_Speed(LPad_Speed),
    .LPad_Remainder_Count(LPad_Remainder_Count), .LPad_Direction(LPad_Direction),
    .LPad_Step(LPad_Step)
  );

  always #5 frame_clk = ~frame_clk;

  int errors = 0;
  int checks = 0;
  int mx [4];
  int mc [4];
  int ms [4];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mx[i] = START_X[i];
      mc[i] = 0;
      ms[i] = SPD[0][i];
    end
  endtask

  // One frame: drive inputs on the falling edge, compare the DUT with the
  // model before the rising edge, then advance the model across that edge.
  task automatic run_frame(input logic rst, input logic en, input logic rs, input logic [1:0] lvl);
    bit exp_step [4];
    @(negedge frame_clk);
    Reset = rst; Enable = en; Restart = rs; Level = lvl;
    #1;
    if (!rst) model_reset();
    for (int i = 0; i < 4; i++) begin
      exp_step[i] = rst && en && !rs && (mc[i] == ms[i] - 1);
      checks++;
      if (LPad_X[i] !== 11'(mx[i])) begin
        errors++;
        $display("FAIL x lane%0d t=%0t got=%0d exp=%0d", i, $time, LPad_X[i], mx[i]);
      end
      checks++;
      if (LPad_Remainder_Count[i] !== 6'(mc[i])) begin
        errors++;
        $display("FAIL cnt lane%0d t=%0t got=%0d exp=%0d", i, $time, LPad_Remainder_Count[i], mc[i]);
      end
      checks++;
      if (LPad_Speed[i] !== 6'(ms[i])) begin
        errors++;
        $display("FAIL speed lane%0d t=%0t got=%0d exp=%0d", i, $time, LPad_Speed[i], ms[i]);
      end
      checks++;
      if (LPad_Step[i] !== exp_step[i]) begin
        errors++;
        $display("FAIL step lane%0d t=%0t got=%0b exp=%0b", i, $time, LPad_Step[i], exp_step[i]);
      end
    end
    @(posedge frame_clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        if (rs) begin
          mx[i] = START_X[i]; mc[i] = 0; ms[i] = SPD[lvl][i];
        end else if (en) begin
          if (exp_step[i]) begin
            mc[i] = 0;
            ms[i] = SPD[lvl][i];
            mx[i] = DIRS[i] ? (mx[i] + STEP) % X_MAX : (mx[i] - STEP + X_MAX) % X_MAX;
          end else begin
            mc[i]++;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++)
      run_frame(1'b0, 1'($urandom), 1'($urandom), 2'($urandom));
    checks++;
    if (LPad_Width !== 11'd80) begin
      errors++;
      $display("FAIL width got=%0d exp=80", LPad_Width);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (LPad_Direction[i] !== 1'(DIRS[i])) begin
        errors++;
        $display("FAIL dir lane%0d got=%0b exp=%0d", i, LPad_Direction[i], DIRS[i]);
      end
    end
  endtask

  task automatic test_basic();
    run_frame(1'b0, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 30; k++) run_frame(1'b1, 1'b1, 1'b0, 2'd0);
    checks++;
    if (LPad_X[0] !== 11'd40 || LPad_Remainder_Count[0] !== 6'd0) begin
      errors++;
      $display("FAIL basic_lane0 got x=%0d cnt=%0d exp x=40 cnt=0", LPad_X[0], LPad_Remainder_Count[0]);
    end
    checks++;
    if (LPad_X[1] !== 11'd360) begin
      errors++;
      $display("FAIL basic_lane1_a got=%0d exp=360", LPad_X[1]);
    end
    for (int k = 0; k < 10; k++) run_frame(1'b1, 1'b1, 1'b0, 2'd0);
    checks++;
    if (LPad_X[1] !== 11'd400) begin
      errors++;
      $display("FAIL basic_lane1_b got=%0d exp=400", LPad_X[1]);
    end
  endtask

  task automatic test_wrap();
    int n;
    run_frame(1'b0, 1'b0, 1'b0, 2'd3);
    n = 0;
    while (!(mx[0] == 0 && mc[0] == ms[0] - 1) && n < 200) begin
      run_frame(1'b1, 1'b1, 1'b0, 2'd3); n++;
    end
    run_frame(1'b1, 1'b1, 1'b0, 2'd3);
    checks++;
    if (n >= 200 || LPad_X[0] !== 11'd600) begin
      errors++;
      $display("FAIL wrap_left got=%0d exp=600 frames=%0d", LPad_X[0], n);
    end
    n = 0;
    while (!(mx[1] == 600 && mc[1] == ms[1] - 1) && n < 200) begin
      run_frame(1'b1, 1'b1, 1'b0, 2'd3); n++;
    end
    run_frame(1'b1, 1'b1, 1'b0, 2'd3);
    checks++;
    if (n >= 200 || LPad_X[1] !== 11'd0) begin
      errors++;
      $display("FAIL wrap_right got=%0d exp=0 frames=%0d", LPad_X[1], n);
    end
  endtask

  task automatic test_level_change();
    run_frame(1'b0, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 10; k++) run_frame(1'b1, 1'b1, 1'b0, 2'd0);
    for (int k = 0; k < 30; k++) run_frame(1'b1, 1'b1, 1'b0, 2'd3);
    checks++;
    if (LPad_X[2] !== 11'd160 || LPad_Speed[2] !== 6'd8 || LPad_Remainder_Count[2] !== 6'd0) begin
      errors++;
      $display("FAIL level_step got x=%0d spd=%0d cnt=%0d exp x=160 spd=8 cnt=0",
               LPad_X[2], LPad_Speed[2], LPad_Remainder_Count[2]);
    end
    for (int k = 0; k < 8; k++) run_frame(1'b1, 1'b1, 1'b0, 2'd3);
    checks++;
    if (LPad_X[2] !== 11'd120) begin
      errors++;
      $display("FAIL level_next got=%0d exp=120", LPad_X[2]);
    end
  endtask

  task automatic test_pause();
    run_frame(1'b0, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 12; k++) run_frame(1'b1, 1'b1, 1'b0, 2'd0);
    for (int k = 0; k < 50; k++) run_frame(1'b1, 1'b0, 1'b0, 2'($urandom));
    checks++;
    if (LPad_Remainder_Count[3] !== 6'd12 || LPad_X[3] !== 11'd440 || LPad_Speed[3] !== 6'd25) begin
      errors++;
      $display("FAIL pause_hold got cnt=%0d x=%0d spd=%0d exp cnt=12 x=440 spd=25",
               LPad_Remainder_Count[3], LPad_X[3], LPad_Speed[3]);
    end
    for (int k = 0; k < 12; k++) run_frame(1'b1, 1'b1, 1'b0, 2'd0);
    checks++;
    if (LPad_X[3] !== 11'd440) begin
      errors++;
      $display("FAIL pause_early got=%0d exp=440", LPad_X[3]);
    end
    run_frame(1'b1, 1'b1, 1'b0, 2'd0);
    checks++;
    if (LPad_X[3] !== 11'd480) begin
      errors++;
      $display("FAIL pause_resume got=%0d exp=480", LPad_X[3]);
    end
  endtask

  task automatic test_restart();
    int n;
    run_frame(1'b0, 1'b0, 1'b0, 2'd2);
    for (int k = 0; k < 45; k++) run_frame(1'b1, 1'b1, 1'b0, 2'd2);
    n = 0;
    while (mc[0] != ms[0] - 1 && n < 100) begin
      run_frame(1'b1, 1'b1, 1'b0, 2'd2); n++;
    end
    run_frame(1'b1, 1'b1, 1'b1, 2'd2);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (n >= 100 || LPad_X[i] !== 11'(START_X[i]) || LPad_Speed[i] !== 6'(SPD[2][i]) ||
          LPad_Remainder_Count[i] !== 6'd0) begin
        errors++;
        $display("FAIL restart lane%0d got x=%0d spd=%0d cnt=%0d exp x=%0d spd=%0d cnt=0",
                 i, LPad_X[i], LPad_Speed[i], LPad_Remainder_Count[i], START_X[i], SPD[2][i]);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 23; k++) run_frame(1'b1, 1'b1, 1'b0, 2'd3);
    @(posedge frame_clk);
    #2;
    Reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (LPad_X[i] !== 11'(START_X[i]) || LPad_Speed[i] !== 6'(SPD[0][i]) ||
          LPad_Remainder_Count[i] !== 6'd0 || LPad_Step[i] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset lane%0d got x=%0d spd=%0d cnt=%0d step=%0b",
                 i, LPad_X[i], LPad_Speed[i], LPad_Remainder_Count[i], LPad_Step[i]);
      end
    end
    model_reset();
    for (int k = 0; k < 4; k++) run_frame(1'b0, 1'($urandom), 1'($urandom), 2'($urandom));
  endtask

  task automatic test_random();
    logic rst, en, rs;
    logic [1:0] lvl;
    lvl = 2'($urandom);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 39) == 0) lvl = 2'($urandom);
      rst = $urandom_range(0, 149) != 0;
      en  = $urandom_range(0, 4) != 0;
      rs  = $urandom_range(0, 99) == 0;
      run_frame(rst, en, rs, lvl);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_wrap();
    test_level_change();
    test_pause();
    test_restart();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
